// File: rtl/triumph_fetch_ctrl.sv
// rtl/triumph_fetch_ctrl.sv - instruction fetch sequencer with PC, imem handshake and fetch buffer
//
// Owns the fetch PC. Issues at most one outstanding instruction-memory request at a time,
// buffers returned words with their PCs in a small FIFO, and applies EX redirects and
// ID back-pressure.
//
// Parameters:
//   BOOT_ADDR   PC after reset (word aligned)
//   FIFO_DEPTH  fetch buffer entries, power of 2, 2..8
//
// Ports:
//   clk_i, rst_i                   clock, synchronous active-high reset
//   fetch_en_i                     allow new requests
//   instr_req_o/instr_addr_o       memory request and word address (registered)
//   instr_gnt_i                    request accepted this cycle
//   instr_rvalid_i/instr_rdata_i   read response
//   redirect_i/redirect_addr_i     flush pulse and restart target
//   id_ready_i                     ID consumes the head entry
//   instr_valid_id_o/_data_/_pc_   head of fetch buffer
//   misalign_err_o                 misaligned redirect pulse
//
// Build option TRIUMPH_FETCH_MISALIGN_EN: a misaligned redirect pulses misalign_err_o and
// parks the fetcher in HALT until an aligned redirect. Without it the low two redirect
// address bits are ignored and misalign_err_o stays 0.

module triumph_fetch_ctrl #(
  parameter logic [31:0] BOOT_ADDR  = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        fetch_en_i,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_addr_i,
  input  logic        id_ready_i,
  output logic        instr_valid_id_o,
  output logic [31:0] instr_data_id_o,
  output logic [31:0] instr_pc_id_o,
  output logic        misalign_err_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

`ifdef TRIUMPH_FETCH_MISALIGN_EN
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HALT} state_e;
`else
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_e;
`endif

  state_e        state_q;
  logic [31:0]   pc_q;
  logic [31:0]   req_pc_q;
  logic [31:0]   addr_q;
  logic          req_q;
  logic          squash_q;
  logic          mis_q;
  logic [31:0]   data_mem_q [FIFO_DEPTH];
  logic [31:0]   pc_mem_q   [FIFO_DEPTH];
  logic [PW-1:0] rptr_q;
  logic [PW-1:0] wptr_q;
  logic [CW-1:0] cnt_q;
`ifdef TRIUMPH_FETCH_MISALIGN_EN
  logic          halt_q;
`endif

  logic [31:0]   redir_pc;
  logic [31:0]   pc_now;
  logic          redir_mis;
  logic          halt_d;
  logic          push;
  logic          pop;
  logic [CW-1:0] cnt_after;
  logic          can_fetch_idle;
  logic          can_fetch_wait;
  state_e        park_state;

  always_comb begin
    redir_pc = {redirect_addr_i[31:2], 2'b00};
    // Address the next request would use if launched this cycle.
    pc_now   = redirect_i ? redir_pc : pc_q;
`ifdef TRIUMPH_FETCH_MISALIGN_EN
    redir_mis  = redirect_i && (redirect_addr_i[1:0] != 2'b00);
    halt_d     = redirect_i ? redir_mis : halt_q;
    park_state = halt_d ? S_HALT : S_IDLE;
`else
    // Low address bits carry no meaning in this build.
    redir_mis  = redirect_i & |(redirect_addr_i[1:0] & 2'b00);
    halt_d     = 1'b0;
    park_state = S_IDLE;
`endif
    // Redirect flushes the buffer, so it suppresses both push and pop.
    push = (state_q == S_WAIT) && instr_rvalid_i && !squash_q && !redirect_i;
    pop  = (cnt_q != '0) && id_ready_i && !redirect_i;
    cnt_after = redirect_i ? '0 : (cnt_q + CW'(push) - CW'(pop));
    can_fetch_idle = fetch_en_i && !halt_d && (cnt_q < CW'(FIFO_DEPTH));
    can_fetch_wait = fetch_en_i && !halt_d && (cnt_after < CW'(FIFO_DEPTH));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      pc_q     <= BOOT_ADDR;
      req_pc_q <= '0;
      addr_q   <= BOOT_ADDR;
      req_q    <= 1'b0;
      squash_q <= 1'b0;
      mis_q    <= 1'b0;
      rptr_q   <= '0;
      wptr_q   <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        data_mem_q[i] <= '0;
        pc_mem_q[i]   <= '0;
      end
`ifdef TRIUMPH_FETCH_MISALIGN_EN
      halt_q   <= 1'b0;
`endif
    end else begin
      mis_q <= redir_mis;
`ifdef TRIUMPH_FETCH_MISALIGN_EN
      halt_q <= halt_d;
`endif

      // Fetch buffer
      if (redirect_i) begin
        rptr_q <= '0;
        wptr_q <= '0;
      end else begin
        if (push) begin
          data_mem_q[wptr_q] <= instr_rdata_i;
          pc_mem_q[wptr_q]   <= req_pc_q;
          wptr_q             <= wptr_q + PW'(1);
        end
        if (pop) begin
          rptr_q <= rptr_q + PW'(1);
        end
      end
      cnt_q <= cnt_after;

      if (redirect_i) begin
        pc_q <= redir_pc;
      end

      case (state_q)
        S_REQ: begin
          // Request and address stay put until granted, even across a redirect.
          if (instr_gnt_i) begin
            req_q    <= 1'b0;
            req_pc_q <= addr_q;
            state_q  <= S_WAIT;
            // While squashing, pc_q already holds the redirect target.
            if (!redirect_i && !squash_q) begin
              pc_q <= pc_q + 32'd4;
            end
          end
          if (redirect_i) begin
            squash_q <= 1'b1;
          end
        end
        S_WAIT: begin
          if (instr_rvalid_i) begin
            squash_q <= 1'b0;
            if (can_fetch_wait) begin
              state_q <= S_REQ;
              req_q   <= 1'b1;
              addr_q  <= pc_now;
            end else begin
              state_q <= park_state;
            end
          end else if (redirect_i) begin
            squash_q <= 1'b1;
          end
        end
        default: begin
          // IDLE (and HALT): nothing outstanding.
          if (can_fetch_idle) begin
            state_q <= S_REQ;
            req_q   <= 1'b1;
            addr_q  <= pc_now;
          end else begin
            state_q <= park_state;
          end
        end
      endcase
    end
  end

  assign instr_req_o      = req_q;
  assign instr_addr_o     = addr_q;
  assign instr_valid_id_o = (cnt_q != '0);
  assign instr_data_id_o  = data_mem_q[rptr_q];
  assign instr_pc_id_o    = pc_mem_q[rptr_q];
  assign misalign_err_o   = mis_q;

endmodule

// File: tb/tb_triumph_fetch_ctrl.sv
// tb/tb_triumph_fetch_ctrl.sv - self-checking bench for triumph_fetch_ctrl
module tb_triumph_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_en;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        redirect;
  logic [31:0] raddr;
  logic        id_ready;
  logic        valid;
  logic [31:0] idata;
  logic [31:0] ipc;
  logic        mis;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  triumph_fetch_ctrl #(
    .BOOT_ADDR (32'h0000_0000),
    .FIFO_DEPTH(2)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .fetch_en_i      (fetch_en),
    .instr_req_o     (req),
    .instr_addr_o    (addr),
    .instr_gnt_i     (gnt),
    .instr_rvalid_i  (rvalid),
    .instr_rdata_i   (rdata),
    .redirect_i      (redirect),
    .redirect_addr_i (raddr),
    .id_ready_i      (id_ready),
    .instr_valid_id_o(valid),
    .instr_data_id_o (idata),
    .instr_pc_id_o   (ipc),
    .misalign_err_o  (mis)
  );

  typedef struct packed {
    logic        fen;
    logic        gnt;
    logic        rv;
    logic [31:0] rd_a;
    logic        rdy;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_v;
    logic [31:0] e_pc;
  } vec_t;

  vec_t tbl[20];

  function automatic logic [31:0] dval(input logic [31:0] a);
    return 32'hC0DE_0000 ^ a;
  endfunction

  function automatic vec_t mk(input logic f, input logic g, input logic r, input logic [31:0] ra,
                              input logic rdy, input logic er, input logic [31:0] ea,
                              input logic ev, input logic [31:0] epc);
    vec_t v;
    v.fen = f; v.gnt = g; v.rv = r; v.rd_a = ra; v.rdy = rdy;
    v.e_req = er; v.e_addr = ea; v.e_v = ev; v.e_pc = epc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, check the current outputs, advance to the next falling edge.
  task automatic cyc(input string tag, input logic f, input logic g, input logic r,
                     input logic [31:0] ra, input logic rdy, input logic rd, input logic [31:0] rda,
                     input logic er, input logic [31:0] ea, input logic ev, input logic [31:0] epc);
    fetch_en = f; gnt = g; rvalid = r; rdata = dval(ra); id_ready = rdy;
    redirect = rd; raddr = rda;
    chk({tag, " req"},   32'(req),   32'(er));
    chk({tag, " addr"},  addr,       ea);
    chk({tag, " valid"}, 32'(valid), 32'(ev));
    if (ev) begin
      chk({tag, " pc"},   ipc,   epc);
      chk({tag, " data"}, idata, dval(epc));
    end
    @(negedge clk);
  endtask

  initial begin
    // fen gnt rv rd_a rdy | req addr valid pc
    tbl[0]  = mk(1, 0, 0, 32'h00, 1, 0, 32'h00, 0, 32'h00);
    tbl[1]  = mk(1, 1, 0, 32'h00, 1, 1, 32'h00, 0, 32'h00);
    tbl[2]  = mk(1, 0, 1, 32'h00, 1, 0, 32'h00, 0, 32'h00);
    tbl[3]  = mk(1, 1, 0, 32'h00, 1, 1, 32'h04, 1, 32'h00);
    tbl[4]  = mk(1, 0, 1, 32'h04, 1, 0, 32'h04, 0, 32'h00);
    tbl[5]  = mk(1, 1, 0, 32'h00, 1, 1, 32'h08, 1, 32'h04);
    tbl[6]  = mk(1, 0, 1, 32'h08, 1, 0, 32'h08, 0, 32'h00);
    tbl[7]  = mk(1, 1, 0, 32'h00, 0, 1, 32'h0C, 1, 32'h08);
    tbl[8]  = mk(1, 0, 1, 32'h0C, 0, 0, 32'h0C, 1, 32'h08);
    tbl[9]  = mk(1, 0, 0, 32'h00, 0, 0, 32'h0C, 1, 32'h08);
    tbl[10] = mk(1, 0, 0, 32'h00, 0, 0, 32'h0C, 1, 32'h08);
    tbl[11] = mk(1, 0, 0, 32'h00, 1, 0, 32'h0C, 1, 32'h08);
    tbl[12] = mk(1, 0, 0, 32'h00, 1, 0, 32'h0C, 1, 32'h0C);
    tbl[13] = mk(1, 1, 0, 32'h00, 0, 1, 32'h10, 0, 32'h00);
    tbl[14] = mk(1, 0, 1, 32'h10, 0, 0, 32'h10, 0, 32'h00);
    tbl[15] = mk(0, 1, 0, 32'h00, 0, 1, 32'h14, 1, 32'h10);
    tbl[16] = mk(0, 0, 1, 32'h14, 0, 0, 32'h14, 1, 32'h10);
    tbl[17] = mk(0, 0, 0, 32'h00, 1, 0, 32'h14, 1, 32'h10);
    tbl[18] = mk(0, 0, 0, 32'h00, 1, 0, 32'h14, 1, 32'h14);
    tbl[19] = mk(0, 0, 0, 32'h00, 1, 0, 32'h14, 0, 32'h00);

    rst = 1'b1; fetch_en = 1'b1; gnt = 1'b0; rvalid = 1'b0; rdata = 32'hDEAD_BEEF;
    redirect = 1'b0; raddr = 32'h0; id_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset req",   32'(req),   32'd0);
    chk("reset addr",  addr,       32'h0);
    chk("reset valid", 32'(valid), 32'd0);
    chk("reset data",  idata,      32'h0);
    chk("reset pc",    ipc,        32'h0);
    chk("reset mis",   32'(mis),   32'd0);
    rst = 1'b0;

    // Streaming fetch, then ID back-pressure filling the buffer, drain, fetch_en drop.
    for (int i = 0; i < 20; i++) begin
      cyc($sformatf("vec%0d", i), tbl[i].fen, tbl[i].gnt, tbl[i].rv, tbl[i].rd_a, tbl[i].rdy,
          1'b0, 32'h0, tbl[i].e_req, tbl[i].e_addr, tbl[i].e_v, tbl[i].e_pc);
    end

    // Grant held off for three cycles.
    cyc("t3a", 1, 0, 0, 32'h00, 1, 0, 32'h0, 0, 32'h14, 0, 32'h0);
    cyc("t3b", 1, 0, 0, 32'h00, 1, 0, 32'h0, 1, 32'h18, 0, 32'h0);
    cyc("t3c", 1, 0, 0, 32'h00, 1, 0, 32'h0, 1, 32'h18, 0, 32'h0);
    cyc("t3d", 1, 0, 0, 32'h00, 1, 0, 32'h0, 1, 32'h18, 0, 32'h0);
    cyc("t3e", 1, 1, 0, 32'h00, 1, 0, 32'h0, 1, 32'h18, 0, 32'h0);
    cyc("t3f", 1, 0, 1, 32'h18, 1, 0, 32'h0, 0, 32'h18, 0, 32'h0);

    // Redirect to 0x100 while waiting for read data.
    cyc("t4a", 1, 1, 0, 32'h00,  1, 0, 32'h0,   1, 32'h1C,  1, 32'h18);
    cyc("t4b", 1, 0, 0, 32'h00,  1, 1, 32'h100, 0, 32'h1C,  0, 32'h0);
    cyc("t4c", 1, 0, 1, 32'h1C,  1, 0, 32'h0,   0, 32'h1C,  0, 32'h0);
    cyc("t4d", 1, 1, 0, 32'h00,  1, 0, 32'h0,   1, 32'h100, 0, 32'h0);
    cyc("t4e", 1, 0, 1, 32'h100, 1, 0, 32'h0,   0, 32'h100, 0, 32'h0);

    // Redirect to 0x200 while a request is still ungranted.
    cyc("t5a", 1, 0, 0, 32'h00,  0, 1, 32'h200, 1, 32'h104, 1, 32'h100);
    cyc("t5b", 1, 0, 0, 32'h00,  0, 0, 32'h0,   1, 32'h104, 0, 32'h0);
    cyc("t5c", 1, 1, 0, 32'h00,  0, 0, 32'h0,   1, 32'h104, 0, 32'h0);
    cyc("t5d", 1, 0, 1, 32'h104, 0, 0, 32'h0,   0, 32'h104, 0, 32'h0);
    cyc("t5e", 1, 1, 0, 32'h00,  0, 0, 32'h0,   1, 32'h200, 0, 32'h0);
    cyc("t5f", 1, 0, 1, 32'h200, 0, 0, 32'h0,   0, 32'h200, 0, 32'h0);
    cyc("t5g", 1, 1, 0, 32'h00,  1, 0, 32'h0,   1, 32'h204, 1, 32'h200);

`ifdef TRIUMPH_FETCH_MISALIGN_EN
    chk("t6a mis", 32'(mis), 32'd0);
    cyc("t6a", 1, 0, 1, 32'h204, 1, 1, 32'h102, 0, 32'h204, 0, 32'h0);
    chk("t6b mis", 32'(mis), 32'd1);
    cyc("t6b", 1, 0, 0, 32'h00, 1, 0, 32'h0, 0, 32'h204, 0, 32'h0);
    chk("t6c mis", 32'(mis), 32'd0);
    cyc("t6c", 1, 0, 0, 32'h00, 1, 0, 32'h0, 0, 32'h204, 0, 32'h0);
    cyc("t6d", 1, 0, 0, 32'h00, 1, 1, 32'h300, 0, 32'h204, 0, 32'h0);
    chk("t6e mis", 32'(mis), 32'd0);
    cyc("t6e", 1, 0, 0, 32'h00, 1, 0, 32'h0, 1, 32'h300, 0, 32'h0);
`else
    cyc("t6a", 1, 0, 1, 32'h204, 1, 1, 32'h302, 0, 32'h204, 0, 32'h0);
    chk("t6b mis", 32'(mis), 32'd0);
    cyc("t6b", 1, 0, 0, 32'h00, 1, 0, 32'h0, 1, 32'h300, 0, 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
